// File: rtl/gain_pkg.sv
// gain_pkg: shared Q-format constants, ramp-state encoding and the
// fixed-point round/saturate helpers used by the gain ramp datapath.
// Helpers work on a 64-bit signed intermediate so one definition serves
// every DWIDTH/GWIDTH combination whose full product fits in 63 bits.
package gain_pkg;

    // Default Q4.12 gain format
    localparam int GAIN_FBITS_DEF  = 12;
    localparam int GAIN_GWIDTH_DEF = 16;
    localparam int GAIN_IBITS_DEF  = GAIN_GWIDTH_DEF - GAIN_FBITS_DEF;
    localparam int GAIN_UNITY      = 1 << GAIN_FBITS_DEF;

    typedef enum logic [1:0] {
        RAMP_IDLE = 2'd0,   // cur == target
        RAMP_UP   = 2'd1,   // cur <  target
        RAMP_DOWN = 2'd2    // cur >  target
    } ramp_state_e;

    // Round half up, then drop the fractional bits (arithmetic shift = floor)
    function automatic logic signed [63:0] round_fx(input logic signed [63:0] p,
                                                    input int fbits);
        logic signed [63:0] half;
        half = 64'sd1 <<< (fbits - 1);
        return (p + half) >>> fbits;
    endfunction

    function automatic logic clip_fx(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        return (v > hi) || (v < lo);
    endfunction

    function automatic logic signed [63:0] sat_fx(input logic signed [63:0] v,
                                                  input int dw);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/gain_ramp_ctrl.sv
// gain_ramp_ctrl: per-channel bank of current gain, target gain and step,
// with the ramp that walks current toward target by one step per processed
// sample.
//   rd_ch_i    channel of the sample being accepted; gain_o is its current gain
//   upd_i      a non-bypass sample was accepted on rd_ch_i this cycle
//   cfg_*_i    target/step load; step 0 also snaps the current gain
module gain_ramp_ctrl
    import gain_pkg::*;
#(
    parameter  int GWIDTH = GAIN_GWIDTH_DEF,
    parameter  int FBITS  = GAIN_FBITS_DEF,
    parameter  int NCH    = 4,
    parameter  int STEP_W = 12,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CW-1:0]            rd_ch_i,
    input  logic                     upd_i,
    input  logic                     cfg_we_i,
    input  logic [CW-1:0]            cfg_ch_i,
    input  logic [GWIDTH-1:0]        cfg_gain_i,
    input  logic [STEP_W-1:0]        cfg_step_i,
    output logic signed [GWIDTH-1:0] gain_o
);

    // Wide enough to hold cur +/- step and target - cur without overflow
    localparam int RW = ((GWIDTH > STEP_W) ? GWIDTH : STEP_W) + 2;
    localparam logic [GWIDTH-1:0] UNITY = {{(GWIDTH-1){1'b0}}, 1'b1} << FBITS;

    logic signed [GWIDTH-1:0] cur_q [NCH];
    logic signed [GWIDTH-1:0] cur_d [NCH];
    logic signed [GWIDTH-1:0] tgt_q [NCH];
    logic signed [GWIDTH-1:0] tgt_d [NCH];
    logic [STEP_W-1:0]        stp_q [NCH];
    logic [STEP_W-1:0]        stp_d [NCH];

    function automatic ramp_state_e ramp_state(input logic signed [GWIDTH-1:0] cur,
                                               input logic signed [GWIDTH-1:0] tgt);
        if (cur == tgt) return RAMP_IDLE;
        if (cur < tgt)  return RAMP_UP;
        return RAMP_DOWN;
    endfunction

    // One ramp step, clamped at target so it never overshoots
    function automatic logic signed [GWIDTH-1:0] ramp_next(
        input logic signed [GWIDTH-1:0] cur,
        input logic signed [GWIDTH-1:0] tgt,
        input logic [STEP_W-1:0]        stp);
        logic signed [RW-1:0] c, t, s;
        c = {{(RW-GWIDTH){cur[GWIDTH-1]}}, cur};
        t = {{(RW-GWIDTH){tgt[GWIDTH-1]}}, tgt};
        s = {{(RW-STEP_W){1'b0}}, stp};
        ramp_next = cur;
        case (ramp_state(cur, tgt))
            RAMP_UP:   ramp_next = (t - c <= s) ? tgt : GWIDTH'(c + s);
            RAMP_DOWN: ramp_next = (c - t <= s) ? tgt : GWIDTH'(c - s);
            default:   ramp_next = cur;
        endcase
    endfunction

    // A config write on the same channel as an accepted sample takes priority
    // over that sample's ramp step; the sample itself already read the old gain.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            cur_d[c] = cur_q[c];
            tgt_d[c] = tgt_q[c];
            stp_d[c] = stp_q[c];
            if (cfg_we_i && cfg_ch_i == CW'(c)) begin
                tgt_d[c] = cfg_gain_i;
                stp_d[c] = cfg_step_i;
                if (cfg_step_i == '0) cur_d[c] = cfg_gain_i;
            end else if (upd_i && rd_ch_i == CW'(c)) begin
                cur_d[c] = ramp_next(cur_q[c], tgt_q[c], stp_q[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                cur_q[c] <= UNITY;
                tgt_q[c] <= UNITY;
                stp_q[c] <= '0;
            end else begin
                cur_q[c] <= cur_d[c];
                tgt_q[c] <= tgt_d[c];
                stp_q[c] <= stp_d[c];
            end
        end
    end

    // Channel indices beyond NCH (non power-of-two NCH) read as unity
    always_comb begin
        gain_o = UNITY;
        for (int c = 0; c < NCH; c++)
            if (rd_ch_i == CW'(c)) gain_o = cur_q[c];
    end

endmodule

// File: rtl/gain_ramp_core.sv
// gain_ramp_core: TDM per-channel gain stage with ramped gain changes.
// Two-stage pipeline: stage 1 registers the full x*g product, stage 2
// rounds half-up, saturates and presents the result. The whole pipe stalls
// when the output is held, so ordering is trivially preserved.
//   s_*      input stream (s_en=0 passes s_data through unchanged)
//   m_*      output stream
//   cfg_*    per-channel target gain / ramp step load
//   sat_flag sticky per-channel clip indicator, cleared by sat_clr
module gain_ramp_core
    import gain_pkg::*;
#(
    parameter  int DWIDTH = 16,
    parameter  int GWIDTH = GAIN_GWIDTH_DEF,
    parameter  int FBITS  = GAIN_FBITS_DEF,
    parameter  int NCH    = 4,
    parameter  int STEP_W = 12,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    input  logic [CW-1:0]     s_ch,
    input  logic              s_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [CW-1:0]     m_ch,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [GWIDTH-1:0] cfg_gain,
    input  logic [STEP_W-1:0] cfg_step,
    output logic [NCH-1:0]    sat_flag,
    input  logic              sat_clr
);

    localparam int PW = DWIDTH + GWIDTH;

    logic signed [GWIDTH-1:0] gain;
    logic signed [PW-1:0]     prod_d, prod_q;
    logic signed [63:0]       rnd;
    logic [DWIDTH-1:0]        y_d;
    logic                     clip;

    logic [1:0]               vld_pipe_q;   // [0] stage 1, [1] output stage
    logic [CW-1:0]            ch1_q, ch2_q;
    logic                     en1_q, clip2_q;
    logic [DWIDTH-1:0]        byp_q, data2_q;
    logic [NCH-1:0]           sat_q, sat_set;

    assign s_ready = !(m_valid && !m_ready);
    assign m_valid = vld_pipe_q[1];
    assign m_data  = data2_q;
    assign m_ch    = ch2_q;
    assign sat_flag = sat_q;

    gain_ramp_ctrl #(
        .GWIDTH (GWIDTH),
        .FBITS  (FBITS),
        .NCH    (NCH),
        .STEP_W (STEP_W)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .rd_ch_i    (s_ch),
        .upd_i      (s_valid && s_ready && s_en),
        .cfg_we_i   (cfg_we),
        .cfg_ch_i   (cfg_ch),
        .cfg_gain_i (cfg_gain),
        .cfg_step_i (cfg_step),
        .gain_o     (gain)
    );

    assign prod_d = $signed({{GWIDTH{s_data[DWIDTH-1]}}, s_data})
                  * $signed({{DWIDTH{gain[GWIDTH-1]}}, gain});

    assign rnd  = round_fx({{(64-PW){prod_q[PW-1]}}, prod_q}, FBITS);
    assign clip = en1_q && clip_fx(rnd, DWIDTH);
    assign y_d  = en1_q ? DWIDTH'(sat_fx(rnd, DWIDTH)) : byp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            prod_q     <= '0;
            ch1_q      <= '0;
            en1_q      <= 1'b0;
            byp_q      <= '0;
            data2_q    <= '0;
            ch2_q      <= '0;
            clip2_q    <= 1'b0;
        end else if (s_ready) begin
            vld_pipe_q <= {vld_pipe_q[0], s_valid};
            if (s_valid) begin
                prod_q <= prod_d;
                ch1_q  <= s_ch;
                en1_q  <= s_en;
                byp_q  <= s_data;
            end
            if (vld_pipe_q[0]) begin
                data2_q <= y_d;
                ch2_q   <= ch1_q;
                clip2_q <= clip;
            end
        end
    end

    // Flag is raised as the clipped sample is handed off; set beats clear
    always_comb begin
        sat_set = '0;
        for (int c = 0; c < NCH; c++)
            sat_set[c] = m_valid && m_ready && clip2_q && (ch2_q == CW'(c));
    end

    always_ff @(posedge clk) begin
        if (rst) sat_q <= '0;
        else     sat_q <= (sat_q & ~{NCH{sat_clr}}) | sat_set;
    end

endmodule

// File: tb/tb_gain_ramp_core.sv
module tb_gain_ramp_core;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0, s_ready, s_en = 1'b1;
    logic [15:0] s_data = '0;
    logic [1:0]  s_ch = '0;
    logic        m_valid, m_ready = 1'b1;
    logic [15:0] m_data;
    logic [1:0]  m_ch;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_gain = '0;
    logic [11:0] cfg_step = '0;
    logic [3:0]  sat_flag;
    logic        sat_clr = 1'b0;

    always #5 clk = ~clk;

    gain_ramp_core dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch), .s_en(s_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain), .cfg_step(cfg_step),
        .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    int checks = 0, errors = 0, cyc = 0;

    typedef struct { int d; int ch; bit clip; int due; } exp_t;
    exp_t   q[$];
    int     obs_d[$];
    longint mcur[NCH], mtgt[NCH], mstp[NCH];
    logic [NCH-1:0] msat;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void mreset();
        for (int i = 0; i < NCH; i++) begin
            mcur[i] = 4096; mtgt[i] = 4096; mstp[i] = 0;
        end
        msat = '0;
        q.delete();
    endfunction

    initial forever begin @(posedge clk); cyc++; end

    // Reference model: spec-level gain/ramp arithmetic and an expected-output queue
    initial begin : mon
        exp_t   e;
        bit     exp_v;
        longint p;
        int     c;
        logic [NCH-1:0] set;
        mreset();
        forever begin
            @(negedge clk);
            if (rst) begin
                mreset();
            end else begin
                exp_v = (q.size() != 0) && (q[0].due <= cyc);
                chk("m_valid", m_valid, exp_v);
                chk("s_ready", s_ready, !(exp_v && !m_ready));
                chk("sat_flag", sat_flag, msat);
                set = '0;
                if (m_valid && exp_v) begin
                    chk("m_data", $signed(m_data), q[0].d);
                    chk("m_ch", m_ch, q[0].ch);
                end
                if (m_valid && m_ready) begin
                    obs_d.push_back(int'($signed(m_data)));
                    if (q.size() != 0) begin
                        if (q[0].clip) set[q[0].ch] = 1'b1;
                        void'(q.pop_front());
                    end
                end
                msat = (sat_clr ? '0 : msat) | set;
                if (s_valid && s_ready) begin
                    c = int'(s_ch);
                    e.ch = c; e.due = cyc + 2; e.clip = 1'b0;
                    if (s_en) begin
                        p = (longint'($signed(s_data)) * mcur[c] + 2048) >>> 12;
                        if (p > 32767)       begin e.d = 32767;  e.clip = 1'b1; end
                        else if (p < -32768) begin e.d = -32768; e.clip = 1'b1; end
                        else                 e.d = int'(p);
                        if (!(cfg_we && int'(cfg_ch) == c)) begin
                            if (mcur[c] < mtgt[c])
                                mcur[c] = (mcur[c] + mstp[c] > mtgt[c]) ? mtgt[c] : mcur[c] + mstp[c];
                            else if (mcur[c] > mtgt[c])
                                mcur[c] = (mcur[c] - mstp[c] < mtgt[c]) ? mtgt[c] : mcur[c] - mstp[c];
                        end
                    end else begin
                        e.d = int'($signed(s_data));
                    end
                    q.push_back(e);
                end
                if (cfg_we) begin
                    mtgt[cfg_ch] = longint'($signed(cfg_gain));
                    mstp[cfg_ch] = longint'(cfg_step);
                    if (cfg_step == 0) mcur[cfg_ch] = longint'($signed(cfg_gain));
                end
            end
        end
    end

    // All stimulus tasks start and end just after a rising edge
    task automatic send(input int d, input int ch, input bit en);
        int n;
        bit ok;
        s_valid = 1'b1; s_data = d[15:0]; s_ch = ch[1:0]; s_en = en;
        n = 0;
        do begin
            @(negedge clk); ok = s_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 100);
        s_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic cfg(input int ch, input int g, input int s);
        cfg_we = 1'b1; cfg_ch = ch[1:0]; cfg_gain = g[15:0]; cfg_step = s[11:0];
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    task automatic chk_obs(input string nm, input int base, input int idx, input int exp);
        chk(nm, (base + idx < obs_d.size()) ? obs_d[base + idx] : -99999, exp);
    endtask

    initial begin
        int base;
        int ramp_exp[6];
        ramp_exp = '{1000, 1250, 1500, 1750, 2000, 2000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_ch", m_ch, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk); #1;

        // unity gain, exact 2-cycle latency
        s_valid = 1'b1; s_data = 16'd1000; s_ch = 2'd0; s_en = 1'b1;
        @(negedge clk); chk("unity_rdy", s_ready, 1);
        @(posedge clk); #1; s_valid = 1'b0;
        @(negedge clk); chk("unity_lat1_valid", m_valid, 0);
        @(negedge clk);
        chk("unity_lat2_valid", m_valid, 1);
        chk("unity_data", $signed(m_data), 1000);
        chk("unity_ch", m_ch, 0);
        @(posedge clk); #1;

        // ramp toward 2.0 in 0.25 steps
        cfg(1, 8192, 1024);
        base = obs_d.size();
        for (int i = 0; i < 6; i++) send(1000, 1, 1'b1);
        drain();
        for (int i = 0; i < 6; i++) chk_obs("ramp", base, i, ramp_exp[i]);

        // saturation both directions, sticky flag and clear
        cfg(2, 8192, 0);
        base = obs_d.size();
        send(20000, 2, 1'b1);
        send(-20000, 2, 1'b1);
        drain();
        chk_obs("sat_pos", base, 0, 32767);
        chk_obs("sat_neg", base, 1, -32768);
        chk("sat_flag_set", sat_flag, 4'b0100);
        sat_clr = 1'b1; @(posedge clk); #1; sat_clr = 1'b0;
        chk("sat_flag_clr", sat_flag, 0);

        // rounding at gain 0.5
        cfg(3, 2048, 0);
        base = obs_d.size();
        send(3, 3, 1'b1);
        send(-3, 3, 1'b1);
        send(5000, 3, 1'b1);
        drain();
        chk_obs("rnd_p3", base, 0, 2);
        chk_obs("rnd_m3", base, 1, -1);
        chk_obs("rnd_5000", base, 2, 2500);

        // backpressure: 3 cycles of m_ready low mid-stream
        base = obs_d.size();
        fork
            begin
                for (int i = 0; i < 8; i++) send(100 + i, 0, 1'b1);
            end
            begin
                repeat (4) begin @(posedge clk); #1; end
                m_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_s_ready", s_ready, 0);
                    chk("bp_hold", $signed(m_data), 102);
                    @(posedge clk); #1;
                end
                m_ready = 1'b1;
            end
        join
        drain();
        for (int i = 0; i < 8; i++) chk_obs("bp_order", base, i, 100 + i);

        // bypass freezes the ramp
        cfg(0, 8192, 1024);
        base = obs_d.size();
        send(1234, 0, 1'b0);
        send(1000, 0, 1'b1);
        send(1000, 0, 1'b1);
        drain();
        chk_obs("byp_data", base, 0, 1234);
        chk_obs("byp_frozen", base, 1, 1000);
        chk_obs("byp_after", base, 2, 1250);

        // reset mid-stream
        send(500, 0, 1'b1);
        send(500, 0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_s_ready", s_ready, 1);
        @(posedge clk); #1;
        base = obs_d.size();
        send(1000, 1, 1'b1);
        send(1000, 2, 1'b1);
        send(1000, 0, 1'b1);
        drain();
        chk_obs("post_rst_ch1", base, 0, 1000);
        chk_obs("post_rst_ch2", base, 1, 1000);
        chk_obs("post_rst_ch0", base, 2, 1000);

        repeat (3) begin @(posedge clk); #1; end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

endmodule

// File: doc/gain_ramp_core.md
GAIN_RAMP_CORE -- requirements
Module: gain_ramp_core

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter GWIDTH, default 16, gain width (signed, Q(GWIDTH-FBITS).FBITS).
REQ-003 SHALL have parameter FBITS, default 12, gain fractional bits (Q4.12 default).
REQ-004 SHALL have parameter NCH, default 4, number of TDM channels (>=1); CW = max(1, clog2(NCH)).
REQ-005 SHALL have parameter STEP_W, default 12, ramp step width (unsigned).
REQ-006 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports s_valid in 1, s_ready out 1, s_data in DWIDTH, s_ch in CW, s_en in 1 (input stream; s_en=0 selects bypass for that sample).
REQ-009 SHALL have ports m_valid out 1, m_ready in 1, m_data out DWIDTH, m_ch out CW (output stream).
REQ-010 SHALL have ports cfg_we in 1, cfg_ch in CW, cfg_gain in GWIDTH (target gain), cfg_step in STEP_W (LSBs per sample).
REQ-011 SHALL have ports sat_flag out NCH (sticky per-channel saturation) and sat_clr in 1.

Function
REQ-012 SHALL transfer on s_valid&s_ready (input) and m_valid&m_ready (output); s_ready = !(m_valid & !m_ready).
REQ-013 SHALL give a latency of exactly 2 cycles from input transfer to m_valid with no stall; stage 1 registers the full product, stage 2 rounds and saturates.
REQ-014 SHALL hold m_data/m_ch stable while m_valid&!m_ready; SHALL not lose, duplicate or reorder samples.
REQ-015 SHALL compute y = sat((x*g + 2^(FBITS-1)) >>> FBITS), where g is the current gain of s_ch at transfer (round half up).
REQ-016 SHALL use a product width of DWIDTH+GWIDTH; saturation limits SHALL be +2^(DWIDTH-1)-1 and -2^(DWIDTH-1).
REQ-017 SHALL give a bypass sample (s_en=0) m_data = s_data with the same latency; the channel ramp SHALL be frozen, and sat_flag SHALL be unaffected.
REQ-018 SHALL keep cur_gain, target and step per channel; ramp state per channel is IDLE (cur==target), UP (cur<target), DOWN (cur>target).
REQ-019 SHALL, after each non-bypass transfer on channel c, step cur_gain[c] by step[c] toward target[c], clamped at target with no overshoot; then IDLE.
REQ-020 SHALL, on cfg_we, load target[cfg_ch] and step[cfg_ch]; cfg_step=0 SHALL load cur_gain[cfg_ch]=cfg_gain immediately (next cycle).
REQ-021 SHALL resolve cfg_we and transfer on the same channel in the same cycle as follows: the sample uses the old cur_gain; cfg wins over the ramp update.
REQ-022 SHALL set sat_flag[c] the cycle after a clipped output for channel c leaves stage 2; on simultaneous sat_clr and set, set wins.

Reset
REQ-023 SHALL, on rst, set m_valid=0, m_data=0, m_ch=0, sat_flag=0, all cur_gain=target=2^FBITS (unity) and all step=0.
REQ-024 SHALL discard in-flight samples when rst is asserted mid-stream; s_ready SHALL be 1 the cycle after rst deasserts.

Structure
REQ-025 SHALL place in package gain_pkg: GAIN_UNITY, Q-format constants, the sat/round function, and the ramp-state enum.
REQ-026 SHALL implement the per-channel gain/target/step bank and ramp FSM in sub-module gain_ramp_ctrl; multiply/round/saturate stays in gain_ramp_core.

Verification
REQ-027 SHALL cover unity gain: ch0, data 1000 -> m_data 1000, m_ch 0, exactly 2 cycles after transfer.
REQ-028 SHALL cover the ramp: cfg ch1 target 8192, step 1024; five ch1 samples of 1000 -> 1000, 1250, 1500, 1750, 2000; a sixth sample -> 2000.
REQ-029 SHALL cover saturation: ch2 gain 8192, step 0; 20000 -> 32767 and -20000 -> -32768; sat_flag[2]=1, other bits 0; sat_clr -> 0.
REQ-030 SHALL cover rounding: gain 2048; 3 -> 2, -3 -> -1, 5000 -> 2500.
REQ-031 SHALL cover backpressure: m_ready low for 3 cycles mid-stream -> s_ready low, m_data held; all samples are delivered in order.
REQ-032 SHALL cover bypass and reset: s_en=0, gain 8192, data 1234 -> 1234 with ramp unchanged; rst mid-stream -> m_valid 0 the next cycle, and the gains are unity afterwards.
